// File: rtl/frame_snapshot_ctrl_pkg.sv
// Shared definitions for the snapshot controller: mode codes, controller state
// encodings and the RGB565 pixel layout.
package frame_snapshot_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE     = 2'd0,
        MODE_SINGLE   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_CONT     = 2'd3
    } mode_e;

    localparam logic [2:0] ST_LIVE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_READOUT = 3'd3;
    localparam logic [2:0] ST_FROZEN  = 3'd4;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_ARM) || (st == ST_CAPTURE) || (st == ST_READOUT);
    endfunction

    // Where a finished readout goes, decided by the mode sampled at the last beat.
    function automatic logic [2:0] readout_exit(input logic [1:0] md);
        logic [2:0] nxt;
        case (md)
            MODE_SINGLE:   nxt = ST_FROZEN;
            MODE_PERIODIC: nxt = ST_LIVE;
            MODE_CONT:     nxt = ST_ARM;
            default:       nxt = ST_LIVE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/frame_snapshot_ctrl_if.sv
// Valid/ready pixel stream carrying a frozen frame with its raster position.
interface frame_snapshot_ctrl_if #(
    parameter int C_NB_PXL  = 16,
    parameter int C_NB_COLS = 7,
    parameter int C_NB_ROWS = 6
);
    logic                 out_valid;
    logic                 out_ready;
    logic [C_NB_PXL-1:0]  out_data;
    logic [C_NB_COLS-1:0] out_x;
    logic [C_NB_ROWS-1:0] out_y;
    logic                 out_sof;
    logic                 out_last;

    modport master (
        output out_valid, out_data, out_x, out_y, out_sof, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_x, out_y, out_sof, out_last,
        output out_ready
    );
endinterface

// File: rtl/frame_snapshot_ctrl_raster_cnt.sv
// Linear pixel index with matching x/y raster coordinates; clear, advance and
// a last-pixel flag.
module frame_snapshot_ctrl_raster_cnt #(
    parameter int C_COLS    = 80,
    parameter int C_ROWS    = 60,
    parameter int C_NB_COLS = 7,
    parameter int C_NB_ROWS = 6,
    parameter int C_NB_PIX  = 13
) (
    input  logic                 wclk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 adv,
    output logic [C_NB_PIX-1:0]  pix,
    output logic [C_NB_PIX-1:0]  pix_inc,
    output logic [C_NB_COLS-1:0] x,
    output logic [C_NB_ROWS-1:0] y,
    output logic                 last
);
    localparam logic [C_NB_PIX-1:0]  C_LAST_PIX = C_NB_PIX'(C_COLS * C_ROWS - 1);
    localparam logic [C_NB_COLS-1:0] C_LAST_X   = C_NB_COLS'(C_COLS - 1);

    logic [C_NB_PIX-1:0]  pix_q, pix_d;
    logic [C_NB_COLS-1:0] x_q, x_d;
    logic [C_NB_ROWS-1:0] y_q, y_d;

    // Next index/coordinates: clear wins over advance; x wraps into y.
    always_comb begin
        pix_d = pix_q;
        x_d   = x_q;
        y_d   = y_q;
        if (clr) begin
            pix_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else if (adv) begin
            pix_d = pix_q + C_NB_PIX'(1);
            if (x_q == C_LAST_X) begin
                x_d = '0;
                y_d = y_q + C_NB_ROWS'(1);
            end else begin
                x_d = x_q + C_NB_COLS'(1);
                y_d = y_q;
            end
        end else begin
            pix_d = pix_q;
        end
    end

    // Counter registers.
    always_ff @(posedge wclk) begin
        if (rst) begin
            pix_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            pix_q <= pix_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign pix     = pix_q;
    assign pix_inc = pix_q + C_NB_PIX'(1);
    assign x       = x_q;
    assign y       = y_q;
    assign last    = (pix_q == C_LAST_PIX);
endmodule

// File: rtl/frame_snapshot_ctrl.sv
// Gates camera frame-buffer writes on whole-frame boundaries and streams a
// frozen frame out over valid/ready in live, single, periodic or continuous mode.
module frame_snapshot_ctrl
    import frame_snapshot_ctrl_pkg::*;
#(
    parameter int C_IMG_COLS    = 80,
    parameter int C_IMG_ROWS    = 60,
    parameter int C_NB_COLS     = 7,
    parameter int C_NB_ROWS     = 6,
    parameter int C_NB_IMG_PXLS = 13,
    parameter int C_NB_PXL      = 16,
    parameter int C_PERIOD      = 8,
    parameter int C_NB_CNT      = 8
) (
    input  logic                     wclk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     trigger,
    input  logic                     hold,
    input  logic                     cap_we_in,
    input  logic [C_NB_IMG_PXLS-1:0] cap_addr_in,
    output logic                     fb_we,
    output logic [C_NB_IMG_PXLS-1:0] rd_addr,
    input  logic [C_NB_PXL-1:0]      rd_data,
    frame_snapshot_ctrl_if.master    strm,
    output logic                     busy,
    output logic [C_NB_CNT-1:0]      frame_cnt,
    output logic [C_NB_CNT-1:0]      snap_cnt
);
    localparam int C_NB_PER = $clog2(C_PERIOD + 1);
    localparam logic [C_NB_IMG_PXLS-1:0] C_LAST_ADDR = C_NB_IMG_PXLS'(C_IMG_COLS * C_IMG_ROWS - 1);
    localparam logic [C_NB_PER-1:0]      C_PER_LAST  = C_NB_PER'(C_PERIOD - 1);

    logic [2:0]          state_q, state_d;
    logic                pending_q, pending_d;
    logic [C_NB_PER-1:0] per_q, per_d;
    logic                valid_q, valid_d;
    logic [C_NB_CNT-1:0] frame_cnt_q, frame_cnt_d;
    logic [C_NB_CNT-1:0] snap_cnt_q, snap_cnt_d;

    logic frame_start_s, frame_end_s, fire_s, go_s, clr_s, adv_s, last_s;
    logic [C_NB_IMG_PXLS-1:0] pix_s, pix_inc_s;
    logic [C_NB_COLS-1:0]     x_s;
    logic [C_NB_ROWS-1:0]     y_s;

    assign frame_start_s = cap_we_in && (cap_addr_in == '0);
    assign frame_end_s   = cap_we_in && (cap_addr_in == C_LAST_ADDR);
    assign fire_s        = valid_q && strm.out_ready;

    frame_snapshot_ctrl_raster_cnt #(
        .C_COLS    (C_IMG_COLS),
        .C_ROWS    (C_IMG_ROWS),
        .C_NB_COLS (C_NB_COLS),
        .C_NB_ROWS (C_NB_ROWS),
        .C_NB_PIX  (C_NB_IMG_PXLS)
    ) u_raster (
        .wclk    (wclk),
        .rst     (rst),
        .clr     (clr_s),
        .adv     (adv_s),
        .pix     (pix_s),
        .pix_inc (pix_inc_s),
        .x       (x_s),
        .y       (y_s),
        .last    (last_s)
    );

    // Snapshot request from LIVE, per mode.
    always_comb begin
        go_s = 1'b0;
        case (mode)
            MODE_SINGLE:   go_s = trigger | pending_q;
            MODE_PERIODIC: go_s = (per_q == C_PER_LAST) & frame_end_s;
            MODE_CONT:     go_s = 1'b1;
            default:       go_s = 1'b0;
        endcase
    end

    // Buffer write gate: hold only matters before the snapshot frame has started.
    always_comb begin
        case (state_q)
            ST_LIVE, ST_ARM: fb_we = cap_we_in & ~hold;
            ST_CAPTURE:      fb_we = cap_we_in;
            default:         fb_we = 1'b0;
        endcase
    end

    // Controller next state, stream valid, pending request and counters.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        per_d       = per_q;
        snap_cnt_d  = snap_cnt_q;
        clr_s       = 1'b0;
        adv_s       = 1'b0;
        frame_cnt_d = frame_end_s ? frame_cnt_q + C_NB_CNT'(1) : frame_cnt_q;
        case (state_q)
            ST_LIVE: begin
                if (go_s) begin
                    state_d = ST_ARM;
                end else if (frame_end_s) begin
                    per_d = (per_q == C_PER_LAST) ? '0 : per_q + C_NB_PER'(1);
                end else begin
                    per_d = per_q;
                end
            end
            ST_ARM: begin
                if (frame_start_s && !hold) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_CAPTURE: begin
                if (frame_end_s) begin
                    state_d = ST_READOUT;
                    clr_s   = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_READOUT: begin
                // Entry cycle only primes the RAM read; valid rises the cycle after.
                adv_s = fire_s && !last_s;
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (fire_s && last_s) begin
                    valid_d    = 1'b0;
                    snap_cnt_d = snap_cnt_q + C_NB_CNT'(1);
                    state_d    = readout_exit(mode);
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_FROZEN: begin
                if (mode != MODE_SINGLE) begin
                    state_d = ST_LIVE;
                end else if (trigger || pending_q) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_FROZEN;
                end
            end
            default: begin
                state_d = ST_LIVE;
                valid_d = 1'b0;
            end
        endcase

        if (state_d != ST_LIVE) begin
            per_d = '0;
        end else begin
            per_d = per_d;
        end
    end

    // One-deep request memory for triggers that arrive while a snapshot is in flight.
    always_comb begin
        if (state_d == ST_ARM && state_q != ST_ARM) begin
            pending_d = 1'b0;
        end else if (trigger && !(state_q == ST_LIVE || state_q == ST_FROZEN)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Controller registers.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q     <= ST_LIVE;
            pending_q   <= 1'b0;
            per_q       <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
            snap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            per_q       <= per_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
            snap_cnt_q  <= snap_cnt_d;
        end
    end

    // Look one address ahead on a beat so the sync RAM keeps full throughput.
    assign rd_addr        = fire_s ? pix_inc_s : pix_s;
    assign strm.out_valid = valid_q;
    assign strm.out_data  = rd_data;
    assign strm.out_x     = x_s;
    assign strm.out_y     = y_s;
    assign strm.out_sof   = valid_q && (pix_s == '0);
    assign strm.out_last  = valid_q && last_s;
    assign busy           = is_busy(state_q);
    assign frame_cnt      = frame_cnt_q;
    assign snap_cnt       = snap_cnt_q;
endmodule

// File: tb/tb_frame_snapshot_ctrl.sv
// Self-checking bench for frame_snapshot_ctrl: an 8x4 image, a behavioural
// frame-buffer and controller model, directed corner cases and random traffic.
module tb_frame_snapshot_ctrl;
    localparam int COLS   = 8;
    localparam int ROWS   = 4;
    localparam int NPIX   = COLS * ROWS;
    localparam int PERIOD = 2;

    logic        wclk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        trigger, hold, cap_we_in;
    logic [12:0] cap_addr_in;
    logic [15:0] cap_data;
    logic        fb_we;
    logic [12:0] rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic [7:0]  frame_cnt, snap_cnt;
    logic [15:0] fbuf [8192];

    frame_snapshot_ctrl_if strm ();

    frame_snapshot_ctrl #(
        .C_IMG_COLS (COLS),
        .C_IMG_ROWS (ROWS),
        .C_PERIOD   (PERIOD)
    ) dut (
        .wclk        (wclk),
        .rst         (rst),
        .mode        (mode),
        .trigger     (trigger),
        .hold        (hold),
        .cap_we_in   (cap_we_in),
        .cap_addr_in (cap_addr_in),
        .fb_we       (fb_we),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .strm        (strm.master),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .snap_cnt    (snap_cnt)
    );

    always #5 wclk = ~wclk;

    // Frame buffer: write port A from the capture side, sync read port B.
    always_ff @(posedge wclk) begin
        if (fb_we) fbuf[cap_addr_in] <= cap_data;
        rd_data <= fbuf[rd_addr];
    end

    // Behavioural reference: snapshot lifecycle phase plus a copy of the image.
    typedef enum {M_LIVE, M_ARM, M_CAP, M_READ, M_FROZEN} phase_t;
    phase_t      m_phase;
    bit          m_pend, m_valid;
    int          m_per, m_pix, m_frames, m_snaps;
    logic [15:0] ref_img [NPIX];

    int passed = 0, total = 0, fires = 0, g_addr = 0;
    bit s_fb_we;
    logic [7:0] s_fcnt;

    typedef struct {
        logic       hold;
        logic       we;
        logic [12:0] addr;
        logic       exp_we;
        logic [7:0] exp_fcnt;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = M_LIVE; m_pend = 0; m_valid = 0;
        m_per = 0; m_pix = 0; m_frames = 0; m_snaps = 0;
    endtask

    // One clock: compare outputs at the falling edge, then step the model.
    task automatic cycle();
        bit fs, fe, wexp, fire;
        @(negedge wclk);
        fs   = cap_we_in && int'(cap_addr_in) == 0;
        fe   = cap_we_in && int'(cap_addr_in) == NPIX - 1;
        wexp = ((m_phase == M_LIVE || m_phase == M_ARM) && cap_we_in && !hold) ||
               (m_phase == M_CAP && cap_we_in);
        fire = m_valid && strm.out_ready;
        s_fb_we = fb_we;
        s_fcnt  = frame_cnt;
        if (strm.out_valid && strm.out_ready) fires++;
        if (!rst) begin
            chk("fb_we", 32'(fb_we), 32'(wexp));
            chk("out_valid", 32'(strm.out_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_phase == M_ARM || m_phase == M_CAP || m_phase == M_READ));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
            chk("snap_cnt", 32'(snap_cnt), 32'(m_snaps));
            if (m_phase == M_READ) chk("rd_addr", 32'(rd_addr), 32'(fire ? m_pix + 1 : m_pix));
            if (m_valid) begin
                chk("out_data", 32'(strm.out_data), 32'(ref_img[m_pix]));
                chk("out_x", 32'(strm.out_x), 32'(m_pix % COLS));
                chk("out_y", 32'(strm.out_y), 32'(m_pix / COLS));
                chk("out_sof", 32'(strm.out_sof), 32'(m_pix == 0));
                chk("out_last", 32'(strm.out_last), 32'(m_pix == NPIX - 1));
            end
        end
        if (wexp) ref_img[cap_addr_in[4:0]] = cap_data;
        if (rst) begin
            model_reset();
        end else begin
            if (fe) m_frames = (m_frames + 1) % 256;
            if (trigger && (m_phase == M_ARM || m_phase == M_CAP || m_phase == M_READ)) m_pend = 1;
            case (m_phase)
                M_LIVE: begin
                    if ((mode == 2'd1 && (trigger || m_pend)) ||
                        (mode == 2'd2 && m_per == PERIOD - 1 && fe) || mode == 2'd3) begin
                        m_phase = M_ARM; m_pend = 0; m_per = 0;
                    end else if (fe) begin
                        m_per = (m_per + 1) % PERIOD;
                    end
                end
                M_ARM: if (fs && !hold) m_phase = M_CAP;
                M_CAP: if (fe) begin m_phase = M_READ; m_pix = 0; m_valid = 0; end
                M_READ: begin
                    if (!m_valid) m_valid = 1;
                    else if (fire) begin
                        if (m_pix == NPIX - 1) begin
                            m_valid = 0;
                            m_snaps = (m_snaps + 1) % 256;
                            case (mode)
                                2'd1:    m_phase = M_FROZEN;
                                2'd3:    begin m_phase = M_ARM; m_pend = 0; end
                                default: m_phase = M_LIVE;
                            endcase
                        end else m_pix++;
                    end
                end
                default: begin
                    if (mode != 2'd1) m_phase = M_LIVE;
                    else if (trigger || m_pend) begin m_phase = M_ARM; m_pend = 0; end
                end
            endcase
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic pix(input bit we);
        cap_we_in   = we;
        cap_addr_in = 13'(g_addr);
        cap_data    = 16'($urandom);
        cycle();
        if (we) g_addr = (g_addr + 1) % NPIX;
    endtask

    task automatic run_frame(output int wr);
        wr = 0;
        for (int i = 0; i < NPIX; i++) begin
            pix(1'b1);
            wr += int'(s_fb_we);
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        pix(1'b0);
        trigger = 1'b0;
    endtask

    task automatic drain_readout(input bit we, input bit toggle);
        int n = 0;
        while ((m_phase == M_CAP || m_phase == M_READ) && n < 300) begin
            if (toggle) strm.out_ready = (n % 2 == 0);
            pix(we);
            n++;
        end
        strm.out_ready = 1'b1;
        chk("readout_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic reset_dut();
        rst = 1'b1; trigger = 1'b0; hold = 1'b0;
        pix(1'b0);
        rst = 1'b0; g_addr = 0; fires = 0;
    endtask

    initial begin
        int wr, gap, nbusy;
        vecs[0] = '{1'b0, 1'b1, 13'd0,  1'b1, 8'd0};
        vecs[1] = '{1'b1, 1'b1, 13'd5,  1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b0, 13'd31, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 1'b1, 13'd31, 1'b1, 8'd0};
        vecs[4] = '{1'b1, 1'b1, 13'd31, 1'b0, 8'd1};
        vecs[5] = '{1'b0, 1'b1, 13'd7,  1'b1, 8'd2};
        vecs[6] = '{1'b1, 1'b0, 13'd0,  1'b0, 8'd2};
        vecs[7] = '{1'b0, 1'b1, 13'd31, 1'b1, 8'd2};

        rst = 1'b1; mode = 2'd0; trigger = 1'b0; hold = 1'b0;
        cap_we_in = 1'b0; cap_addr_in = '0; cap_data = '0; strm.out_ready = 1'b1;
        repeat (2) @(posedge wclk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("reset_valid", 32'(strm.out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_counts", 32'({frame_cnt, snap_cnt}), 32'd0);

        // LIVE write gating and ungated frame counting.
        foreach (vecs[i]) begin
            hold = vecs[i].hold; cap_we_in = vecs[i].we;
            cap_addr_in = vecs[i].addr; cap_data = 16'($urandom);
            cycle();
            chk("tbl_fb_we", 32'(s_fb_we), 32'(vecs[i].exp_we));
            chk("tbl_frame_cnt", 32'(s_fcnt), 32'(vecs[i].exp_fcnt));
        end
        chk("tbl_frame_cnt_end", 32'(frame_cnt), 32'd3);

        // LIVE mode: every write passes, nothing streams.
        reset_dut();
        for (int f = 0; f < 3; f++) begin
            run_frame(wr);
            chk("live_writes", 32'(wr), 32'(NPIX));
        end
        chk("live_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("live_no_stream", 32'(fires), 32'd0);

        // SINGLE: trigger mid-frame, capture next whole frame, stream, freeze.
        reset_dut();
        mode = 2'd1;
        for (int i = 0; i < 10; i++) pix(1'b1);
        trigger = 1'b1; pix(1'b1); trigger = 1'b0;
        hold = 1'b1; gap = 0;
        for (int i = 11; i < NPIX; i++) begin pix(1'b1); gap += int'(s_fb_we); end
        hold = 1'b0;
        chk("single_gap_we", 32'(gap), 32'd0);
        run_frame(wr);
        chk("single_capture_we", 32'(wr), 32'(NPIX));
        drain_readout(1'b0, 1'b0);
        chk("single_beats", 32'(fires), 32'(NPIX));
        chk("single_frozen_busy", 32'(busy), 32'd0);
        chk("single_snap_cnt", 32'(snap_cnt), 32'd1);
        run_frame(wr);
        chk("frozen_no_we", 32'(wr), 32'd0);

        // Readout under 1010 backpressure while the camera keeps writing.
        reset_dut();
        mode = 2'd1;
        pulse_trigger();
        run_frame(wr);
        drain_readout(1'b1, 1'b1);
        chk("bp_beats", 32'(fires), 32'(NPIX));

        // PERIODIC: snapshot armed by the second frame_end seen in LIVE.
        reset_dut();
        mode = 2'd2;
        run_frame(wr);
        chk("per_first_idle", 32'(busy), 32'd0);
        run_frame(wr);
        chk("per_armed", 32'(busy), 32'd1);
        run_frame(wr);
        drain_readout(1'b1, 1'b0);
        chk("per_back_live", 32'(busy), 32'd0);
        chk("per_snap_cnt", 32'(snap_cnt), 32'd1);
        for (int f = 0; f < 4; f++) run_frame(wr);

        // hold keeps ARM from starting across whole frames.
        reset_dut();
        mode = 2'd1; hold = 1'b1;
        pulse_trigger();
        gap = 0;
        for (int f = 0; f < 2; f++) begin run_frame(wr); gap += wr; end
        chk("hold_no_we", 32'(gap), 32'd0);
        chk("hold_still_armed", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) pix(1'b1);
        hold = 1'b0;
        for (int i = 5; i < NPIX; i++) pix(1'b1);
        run_frame(wr);
        chk("hold_capture_we", 32'(wr), 32'(NPIX));
        drain_readout(1'b0, 1'b0);
        chk("hold_beats", 32'(fires), 32'(NPIX));

        // Reset in the middle of a readout with a request pending.
        reset_dut();
        mode = 2'd1;
        pulse_trigger();
        run_frame(wr);
        trigger = 1'b1; pix(1'b1); trigger = 1'b0;
        for (int n = 0; n < 100 && !(m_valid && m_pix == 17); n++) pix(1'b1);
        chk("rst_reached_pix17", 32'(m_pix), 32'd17);
        rst = 1'b1; pix(1'b1); rst = 1'b0;
        chk("rst_valid", 32'(strm.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_counts", 32'({frame_cnt, snap_cnt}), 32'd0);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin pix(1'b1); nbusy += int'(busy); end
        chk("rst_pending_gone", 32'(nbusy), 32'd0);

        // Random traffic against the model.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 2) mode = 2'($urandom_range(3));
            if ($urandom_range(99) < 3) hold = ~hold;
            trigger = ($urandom_range(99) < 3);
            strm.out_ready = ($urandom_range(99) < 70);
            pix($urandom_range(99) < 80);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end
endmodule
